snd_envelope: RTL and testbench
===============================

SND_ENVELOPE -- requirements
Module: snd_envelope

Interface
REQ-001 SHALL provide parameter WIN_BITS, default 8, meaning log2 of the input averaging window length in clocks.
REQ-002 SHALL provide parameter ENV_BITS, default 8, meaning the width of the envelope level.
REQ-003 SHALL provide parameter RAMP_DIV, default 1024, meaning clocks per envelope step.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL provide port gate, input, 1 bit: high requests sound, low requests fade-out.
REQ-007 SHALL provide port snd_in, input, 1 bit: the PWM audio from the square-wave mixer stage.
REQ-008 SHALL provide port snd_out, output, 1 bit: the enveloped first-order sigma-delta audio.
REQ-009 SHALL provide port active, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL provide port env, output, ENV_BITS bits: the current envelope level.

Function
REQ-011 Window counter SHALL count 0..2^WIN_BITS-1 and wrap; ones counter (WIN_BITS+1 bits) SHALL count cycles with snd_in=1 within the window.
REQ-012 On the last window cycle, level (WIN_BITS bits) SHALL latch the ones count including that cycle's snd_in, saturated to 2^WIN_BITS-1; ones counter SHALL restart from 0 on the next cycle.
REQ-013 Ramp divider SHALL run free modulo RAMP_DIV and pulse tick for one cycle when the count equals RAMP_DIV-1.
REQ-014 FSM states SHALL be IDLE, ATTACK, SUSTAIN and RELEASE.
REQ-015 IDLE: env=0; gate=1 -> ATTACK.
REQ-016 ATTACK: on tick, env+1; when env reaches 2^ENV_BITS-1 -> SUSTAIN; gate=0 -> RELEASE with env unchanged; gate=0 takes priority over a same-cycle tick.
REQ-017 SUSTAIN: env held at maximum; gate=0 -> RELEASE.
REQ-018 RELEASE: on tick, env-1; when env reaches 0 -> IDLE; gate=1 -> ATTACK continuing from the current env, with gate=1 taking priority over a same-cycle tick.
REQ-019 env SHALL never wrap past 0 or past 2^ENV_BITS-1.
REQ-020 scaled SHALL be (level*env)>>ENV_BITS, computed full-width and then truncated to WIN_BITS bits.
REQ-021 Modulator SHALL compute {carry,acc} <= acc + scaled each cycle, with acc WIN_BITS bits; snd_out SHALL be the registered carry, 1 clock after acc updates.
REQ-022 With constant scaled=S, snd_out SHALL emit exactly S ones in every 2^WIN_BITS consecutive cycles once settled.
REQ-023 env and active SHALL be registered outputs reflecting the current state.

Reset
REQ-024 On reset=1 at a clock edge, the following SHALL all be 0 on the next cycle: state (IDLE), env, level, window counter, ones counter, ramp counter, acc, snd_out and active.
REQ-025 Reset SHALL take priority over gate, tick and window events in any state, including mid-ATTACK and mid-RELEASE.
REQ-026 Post-reset, the first level latch SHALL occur 2^WIN_BITS cycles after reset deasserts.

Structure
REQ-027 State encoding (2-bit enum IDLE/ATTACK/SUSTAIN/RELEASE) SHALL reside in a shared package snd_env_pkg.
REQ-028 The ramp tick generator SHALL be a sub-module snd_env_tick (parameter DIV, ports clk, reset, tick).
REQ-029 Implementation SHALL contain no combinational path from any input to snd_out, active or env.

Verification (bench params WIN_BITS=4, ENV_BITS=4, RAMP_DIV=4)
REQ-030 Reset scenario: assert reset 3 cycles -> snd_out=0, active=0, env=0, state IDLE.
REQ-031 Full-scale scenario: gate=1, snd_in=1 constant -> env steps 0..15 over 60 clocks and enters SUSTAIN; level=15 (saturated from 16); snd_out gives exactly 14 ones per 16 cycles.
REQ-032 Silent-input scenario: gate=1, snd_in=0 -> snd_out stays 0 indefinitely while env still reaches 15.
REQ-033 Early-release scenario: gate drops when env=7 in ATTACK -> RELEASE; env reaches 0 after 7 ticks (28 clocks) -> IDLE, active=0.
REQ-034 Re-attack scenario: gate rises when env=5 in RELEASE -> ATTACK, next tick env=6; a coincident tick on the gate edge cycle produces no decrement.
REQ-035 Mid-operation reset scenario: reset pulsed in SUSTAIN with acc nonzero -> all registers 0 next cycle; gate still 1 -> ATTACK on the following cycle.

Source files
------------

// File: rtl/snd_env_pkg.sv
// Shared types for the sound envelope: FSM state encoding and a counter-width helper.
package snd_env_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snd_envelope_if.sv
// Signal bundle around the envelope block: gate/audio in, enveloped audio and status out.
interface snd_envelope_if #(parameter int ENV_BITS = 8);
  logic                gate;
  logic                snd_in;
  logic                snd_out;
  logic                active;
  logic [ENV_BITS-1:0] env;

  modport master (output gate, snd_in, input snd_out, active, env);
  modport slave  (input gate, snd_in, output snd_out, active, env);
endinterface

// File: rtl/snd_env_tick.sv
// Free-running ramp divider; tick is high for the one cycle the count sits at DIV-1.
module snd_env_tick
  import snd_env_pkg::*;
#(
  parameter int DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/snd_envelope.sv
// ADSR-style envelope on a PWM audio stream: windowed level measurement, scaling by
// the envelope, and first-order sigma-delta re-modulation.
//
// state   | meaning
// IDLE    | silent, env forced to 0
// ATTACK  | env ramps up one step per tick
// SUSTAIN | env held at full scale
// RELEASE | env ramps down one step per tick
module snd_envelope
  import snd_env_pkg::*;
#(
  parameter int WIN_BITS = 8,
  parameter int ENV_BITS = 8,
  parameter int RAMP_DIV = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gate,
  input  logic                snd_in,
  output logic                snd_out,
  output logic                active,
  output logic [ENV_BITS-1:0] env
);

  localparam logic [WIN_BITS-1:0] WIN_LAST = '1;
  localparam logic [ENV_BITS-1:0] ENV_MAX  = '1;
  localparam logic [ENV_BITS-1:0] ENV_ONE  = ENV_BITS'(1);

  logic [WIN_BITS-1:0]          win_cnt;
  logic [WIN_BITS:0]            ones;
  logic [WIN_BITS:0]            ones_total;
  logic [WIN_BITS-1:0]          level;
  logic [WIN_BITS+ENV_BITS-1:0] product;
  logic [WIN_BITS-1:0]          scaled;
  logic [WIN_BITS-1:0]          acc;
  logic [WIN_BITS:0]            sum;
  logic                         carry;
  logic                         tick;
  env_state_t                   state, state_nxt;
  logic [ENV_BITS-1:0]          env_nxt;

  snd_env_tick #(.DIV(RAMP_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // The last window cycle's sample is folded in before latching.
  assign ones_total = ones + {{WIN_BITS{1'b0}}, snd_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt <= '0;
      ones    <= '0;
      level   <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_BITS'(1);
      if (win_cnt == WIN_LAST) begin
        ones  <= '0;
        level <= ones_total[WIN_BITS] ? '1 : ones_total[WIN_BITS-1:0];
      end else begin
        ones  <= ones_total;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    unique case (state)
      IDLE: begin
        env_nxt = '0;
        if (gate) state_nxt = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          state_nxt = RELEASE;
        end else if (env == ENV_MAX) begin
          state_nxt = SUSTAIN;
        end else if (tick) begin
          env_nxt = env + ENV_ONE;
          if (env == ENV_MAX - ENV_ONE) state_nxt = SUSTAIN;
        end
      end
      SUSTAIN: begin
        env_nxt = ENV_MAX;
        if (!gate) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (gate) begin
          state_nxt = ATTACK;
        end else if (env == '0) begin
          state_nxt = IDLE;
        end else if (tick) begin
          env_nxt = env - ENV_ONE;
          if (env == ENV_ONE) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      env    <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      env    <= env_nxt;
      active <= (state_nxt != IDLE);
    end
  end

  assign product = {{ENV_BITS{1'b0}}, level} * {{WIN_BITS{1'b0}}, env};
  assign scaled  = product[ENV_BITS +: WIN_BITS];
  assign sum     = {1'b0, acc} + {1'b0, scaled};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      carry   <= 1'b0;
      snd_out <= 1'b0;
    end else begin
      {carry, acc} <= sum;
      snd_out      <= carry;
    end
  end

endmodule

// File: tb/tb_snd_envelope.sv
// Scoreboard bench for snd_envelope (WIN_BITS=4, ENV_BITS=4, RAMP_DIV=4).
module tb_snd_envelope;

  localparam logic [3:0] M_ENV  = 4'b0001;
  localparam logic [3:0] M_ACT  = 4'b0010;
  localparam logic [3:0] M_SND  = 4'b0100;
  localparam logic [3:0] M_ONES = 4'b1000;

  typedef struct {
    int         due;
    string      name;
    logic [3:0] mask;
    logic [3:0] env;
    logic       act;
    logic       snd;
    int         ones;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   r;
  logic [15:0] hist = '0;
  exp_t sb[$];

  snd_envelope_if #(.ENV_BITS(4)) bus ();

  snd_envelope #(.WIN_BITS(4), .ENV_BITS(4), .RAMP_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .gate    (bus.gate),
    .snd_in  (bus.snd_in),
    .snd_out (bus.snd_out),
    .active  (bus.active),
    .env     (bus.env)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int due, input string name, input logic [3:0] mask,
                      input logic [3:0] e_env, input logic e_act, input logic e_snd,
                      input int e_ones);
    exp_t e;
    e.due = due; e.name = name; e.mask = mask;
    e.env = e_env; e.act = e_act; e.snd = e_snd; e.ones = e_ones;
    sb.push_back(e);
  endtask

  // Monitor: samples just after the falling edge and retires due expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      hist = {hist[14:0], bus.snd_out};
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL %s: check for cycle %0d skipped at cycle %0d", e.name, e.due, cyc);
        end else begin
          if (e.mask & M_ENV) begin
            n_cmp++;
            if (bus.env !== e.env) begin
              n_bad++;
              $display("FAIL %s env @%0d: got %0d want %0d", e.name, cyc, bus.env, e.env);
            end
          end
          if (e.mask & M_ACT) begin
            n_cmp++;
            if (bus.active !== e.act) begin
              n_bad++;
              $display("FAIL %s active @%0d: got %b want %b", e.name, cyc, bus.active, e.act);
            end
          end
          if (e.mask & M_SND) begin
            n_cmp++;
            if (bus.snd_out !== e.snd) begin
              n_bad++;
              $display("FAIL %s snd_out @%0d: got %b want %b", e.name, cyc, bus.snd_out, e.snd);
            end
          end
          if (e.mask & M_ONES) begin
            n_cmp++;
            if ($countones(hist) != e.ones) begin
              n_bad++;
              $display("FAIL %s ones/16 @%0d: got %0d want %0d", e.name, cyc, $countones(hist), e.ones);
            end
          end
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Leaves r = index of the last edge that sampled reset high.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; bus.gate = 1'b0; bus.snd_in = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    r = cyc;
  endtask

  initial begin
    reset = 1'b1; bus.gate = 1'b0; bus.snd_in = 1'b0;

    // Reset, then idle with gate low
    do_reset(3);
    push(r,     "reset",      M_ENV | M_ACT | M_SND, 4'd0, 1'b0, 1'b0, 0);
    push(r + 5, "reset_idle", M_ENV | M_ACT | M_SND, 4'd0, 1'b0, 1'b0, 0);
    wait_until(r + 8);

    // Full-scale input: attack to sustain, level saturates at 15, 14 ones per window
    do_reset(3);
    push(r + 1,   "fs_start", M_ENV | M_ACT, 4'd0,  1'b1, 1'b0, 0);
    push(r + 3,   "fs_pre",   M_ENV,         4'd0,  1'b0, 1'b0, 0);
    push(r + 4,   "fs_tick1", M_ENV,         4'd1,  1'b0, 1'b0, 0);
    push(r + 8,   "fs_tick2", M_ENV,         4'd2,  1'b0, 1'b0, 0);
    push(r + 17,  "fs_snd0",  M_SND,         4'd0,  1'b0, 1'b0, 0);
    push(r + 59,  "fs_env14", M_ENV,         4'd14, 1'b0, 1'b0, 0);
    push(r + 60,  "fs_env15", M_ENV | M_ACT, 4'd15, 1'b1, 1'b0, 0);
    push(r + 100, "fs_dens1", M_ENV | M_ONES, 4'd15, 1'b0, 1'b0, 14);
    push(r + 116, "fs_dens2", M_ONES,        4'd0,  1'b0, 1'b0, 14);
    bus.gate = 1'b1; bus.snd_in = 1'b1;
    wait_until(r + 120);

    // Silent input: envelope still completes, output stays zero
    do_reset(3);
    push(r + 60,  "sil_env",   M_ENV | M_ACT, 4'd15, 1'b1, 1'b0, 0);
    push(r + 80,  "sil_dens1", M_ONES,        4'd0,  1'b0, 1'b0, 0);
    push(r + 120, "sil_dens2", M_ENV | M_ONES | M_SND, 4'd15, 1'b0, 1'b0, 0);
    bus.gate = 1'b1; bus.snd_in = 1'b0;
    wait_until(r + 122);

    // Early release at env=7, decays back to IDLE
    do_reset(3);
    push(r + 28, "er_env7",  M_ENV,         4'd7, 1'b0, 1'b0, 0);
    push(r + 30, "er_rel",   M_ENV | M_ACT, 4'd7, 1'b1, 1'b0, 0);
    push(r + 32, "er_dec1",  M_ENV,         4'd6, 1'b0, 1'b0, 0);
    push(r + 55, "er_env1",  M_ENV | M_ACT, 4'd1, 1'b1, 1'b0, 0);
    push(r + 56, "er_idle",  M_ENV | M_ACT, 4'd0, 1'b0, 1'b0, 0);
    push(r + 64, "er_stay",  M_ENV | M_ACT, 4'd0, 1'b0, 1'b0, 0);
    bus.gate = 1'b1; bus.snd_in = 1'b1;
    wait_until(r + 29);
    bus.gate = 1'b0;
    wait_until(r + 66);

    // Re-attack at env=5 on a tick edge, then release on a tick edge
    do_reset(3);
    push(r + 38, "ra_env5",   M_ENV | M_ACT, 4'd5, 1'b1, 1'b0, 0);
    push(r + 40, "ra_coinc",  M_ENV | M_ACT, 4'd5, 1'b1, 1'b0, 0);
    push(r + 43, "ra_hold",   M_ENV,         4'd5, 1'b0, 1'b0, 0);
    push(r + 44, "ra_inc",    M_ENV,         4'd6, 1'b0, 1'b0, 0);
    push(r + 52, "ra_env8",   M_ENV,         4'd8, 1'b0, 1'b0, 0);
    push(r + 56, "rel_coinc", M_ENV | M_ACT, 4'd8, 1'b1, 1'b0, 0);
    push(r + 59, "rel_hold",  M_ENV,         4'd8, 1'b0, 1'b0, 0);
    push(r + 60, "rel_dec",   M_ENV,         4'd7, 1'b0, 1'b0, 0);
    bus.gate = 1'b1; bus.snd_in = 1'b1;
    wait_until(r + 29);
    bus.gate = 1'b0;
    wait_until(r + 39);
    bus.gate = 1'b1;
    wait_until(r + 55);
    bus.gate = 1'b0;
    wait_until(r + 62);

    // Reset pulsed in SUSTAIN with the modulator running, gate held high
    do_reset(3);
    push(r + 70, "mr_sus",   M_ENV | M_ACT, 4'd15, 1'b1, 1'b0, 0);
    push(r + 71, "mr_clear", M_ENV | M_ACT | M_SND, 4'd0, 1'b0, 1'b0, 0);
    push(r + 72, "mr_att",   M_ENV | M_ACT | M_SND, 4'd0, 1'b1, 1'b0, 0);
    push(r + 74, "mr_pre",   M_ENV,         4'd0,  1'b0, 1'b0, 0);
    push(r + 75, "mr_tick",  M_ENV,         4'd1,  1'b0, 1'b0, 0);
    push(r + 87, "mr_quiet", M_ONES,        4'd0,  1'b0, 1'b0, 0);
    bus.gate = 1'b1; bus.snd_in = 1'b1;
    wait_until(r + 70);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_until(r + 90);

    repeat (3) @(negedge clk);
    #2;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s: check for cycle %0d never reached", e.name, e.due);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
